// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO with storage, occupancy/threshold flags, sticky error flags and a registered read port.
// Read data lands one edge after an accepted rinc; writes while full and reads while empty are dropped and flagged.
module sync_fifo_ctl #(
  parameter int DATASIZE     = 8,
  parameter int ADDRSIZE     = 9,
  parameter int AFULL_LEVEL  = (1 << ADDRSIZE) - 4,
  parameter int AEMPTY_LEVEL = 4
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                clr,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  output logic                wfull,
  output logic                rempty,
  output logic                afull,
  output logic                aempty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] DEPTH_C  = (ADDRSIZE+1)'(DEPTH);
  localparam logic [ADDRSIZE:0] AFULL_C  = (ADDRSIZE+1)'(AFULL_LEVEL);
  localparam logic [ADDRSIZE:0] AEMPTY_C = (ADDRSIZE+1)'(AEMPTY_LEVEL);

  logic [DATASIZE-1:0] mem [DEPTH];
  logic [ADDRSIZE:0]   wptr;
  logic [ADDRSIZE:0]   rptr;
  logic                wr_ok;
  logic                rd_ok;

  // The extra pointer bit makes full (count==DEPTH) distinct from empty.
  assign count  = wptr - rptr;
  assign wfull  = (count == DEPTH_C);
  assign rempty = (count == '0);
  assign afull  = (count >= AFULL_C);
  assign aempty = (count <= AEMPTY_C);

  assign wr_ok = winc && !wfull;
  assign rd_ok = rinc && !rempty;

  always_ff @(posedge wclk) begin
    if (wr_ok && !clr) begin
      mem[wptr[ADDRSIZE-1:0]] <= wdata;
    end
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wptr      <= '0;
      rptr      <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      rvalid    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_ok) begin
        rptr  <= rptr + 1'b1;
        rdata <= mem[rptr[ADDRSIZE-1:0]];
      end
      rvalid <= rd_ok;
      if (winc && wfull) begin
        overflow <= 1'b1;
      end
      if (rinc && rempty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule
